// File: rtl/branch_cmp_pkg.sv
// Shared op codes and the branch-condition evaluator for branch_cmp_pipe.
// Operands arrive zero-extended to CMP_MAX_W; the live width is passed explicitly.
package branch_cmp_pkg;

    localparam int CMP_MAX_W = 64;

    typedef logic [2:0] cmp_op_t;

    localparam cmp_op_t CMP_EQ  = 3'd0;
    localparam cmp_op_t CMP_NE  = 3'd1;
    localparam cmp_op_t CMP_LTS = 3'd2;
    localparam cmp_op_t CMP_GES = 3'd3;
    localparam cmp_op_t CMP_LTU = 3'd4;
    localparam cmp_op_t CMP_GEU = 3'd5;
    localparam cmp_op_t CMP_LEZ = 3'd6;
    localparam cmp_op_t CMP_GTZ = 3'd7;

    // Signed order is taken from the sign bits first, so no subtract overflow can leak in.
    function automatic logic cmp_eval(
        input cmp_op_t                op,
        input logic [CMP_MAX_W-1:0]   a,
        input logic [CMP_MAX_W-1:0]   b,
        input int unsigned            width
    );
        logic [5:0] msb_s;
        logic       sa_s;
        logic       sb_s;
        logic       eq_s;
        logic       ltu_s;
        logic       lts_s;
        logic       az_s;
        logic       res_s;
        msb_s = 6'(width - 32'd1);
        sa_s  = a[msb_s];
        sb_s  = b[msb_s];
        eq_s  = (a == b);
        ltu_s = (a < b);
        lts_s = (sa_s != sb_s) ? sa_s : ltu_s;
        az_s  = (a == {CMP_MAX_W{1'b0}});
        case (op)
            CMP_EQ:  res_s = eq_s;
            CMP_NE:  res_s = ~eq_s;
            CMP_LTS: res_s = lts_s;
            CMP_GES: res_s = ~lts_s;
            CMP_LTU: res_s = ltu_s;
            CMP_GEU: res_s = ~ltu_s;
            CMP_LEZ: res_s = sa_s | az_s;
            CMP_GTZ: res_s = ~sa_s & ~az_s;
            default: res_s = 1'b0;
        endcase
        return res_s;
    endfunction

endpackage

// File: rtl/branch_cmp_stage.sv
// One elastic register slice: holds {valid, data} and accepts whenever it is
// empty or its content leaves in the same cycle.
module branch_cmp_stage #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_r;
    logic [DW-1:0] data_r;
    logic          ready_s;

    assign ready_s   = ~valid_r | out_ready;
    assign in_ready  = ready_s;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Load on free/advancing slot; data is left untouched when nothing new arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DW{1'b0}};
        end else if (ready_s) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined MIPS branch-condition comparator with valid/ready flow control.
// Optional macro BRANCH_CMP_STATS_EN adds stat_total/stat_taken handshake counters.
module branch_cmp_pipe
    import branch_cmp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [TAG_W-1:0] out_tag
`ifdef BRANCH_CMP_STATS_EN
    ,
    output logic [31:0]      stat_total,
    output logic [31:0]      stat_taken
`endif
);

    localparam int DW = TAG_W + 1;

    generate
        if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
            $error("branch_cmp_pipe: STAGES must be 1 or 2");
        end
        if (WIDTH < 2 || WIDTH > CMP_MAX_W) begin : g_bad_width
            $error("branch_cmp_pipe: WIDTH out of range");
        end
    endgenerate

    logic [CMP_MAX_W-1:0] a_ext_s;
    logic [CMP_MAX_W-1:0] b_ext_s;
    logic                 taken_s;

    assign a_ext_s = CMP_MAX_W'(in_a);
    assign b_ext_s = CMP_MAX_W'(in_b);

    // Condition is resolved before the first register so stage 0 captures a single bit.
    always_comb begin
        taken_s = 1'b0;
        taken_s = cmp_eval(cmp_op_t'(in_op), a_ext_s, b_ext_s, WIDTH);
    end

    // Chain index k is the input side of stage k; index STAGES is the pipe output.
    logic          v_s [0:STAGES];
    logic          r_s [0:STAGES];
    logic [DW-1:0] d_s [0:STAGES];

    assign v_s[0]      = in_valid;
    assign d_s[0]      = {taken_s, in_tag};
    assign in_ready    = r_s[0];
    assign r_s[STAGES] = out_ready;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            branch_cmp_stage #(.DW(DW)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (v_s[k]),
                .in_ready  (r_s[k]),
                .in_data   (d_s[k]),
                .out_valid (v_s[k+1]),
                .out_ready (r_s[k+1]),
                .out_data  (d_s[k+1])
            );
        end
    endgenerate

    assign out_valid = v_s[STAGES];
    assign out_taken = d_s[STAGES][DW-1];
    assign out_tag   = d_s[STAGES][TAG_W-1:0];

`ifdef BRANCH_CMP_STATS_EN
    logic [31:0] stat_total_r;
    logic [31:0] stat_taken_r;

    // Count every output handshake, and separately those that were taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total_r <= 32'd0;
            stat_taken_r <= 32'd0;
        end else if (out_valid && out_ready) begin
            stat_total_r <= stat_total_r + 32'd1;
            if (out_taken) begin
                stat_taken_r <= stat_taken_r + 32'd1;
            end
        end
    end

    assign stat_total = stat_total_r;
    assign stat_taken = stat_taken_r;
`endif

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Randomised self-checking bench: a STAGES=2 instance with backpressure and a
// STAGES=1 instance fed the same accepted requests, both against a queue model.
module tb_branch_cmp_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready2, out_valid2, out_taken2;
    logic [7:0]  out_tag2;
    logic        in_valid1, in_ready1, out_valid1, out_taken1;
    logic [7:0]  out_tag1;
`ifdef BRANCH_CMP_STATS_EN
    logic [31:0] stat_total2, stat_taken2, stat_total1, stat_taken1;
`endif

    always #5 clk = ~clk;

    assign in_valid1 = in_valid & in_ready2;

    branch_cmp_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready), .out_taken(out_taken2), .out_tag(out_tag2)
`ifdef BRANCH_CMP_STATS_EN
        , .stat_total(stat_total2), .stat_taken(stat_taken2)
`endif
    );

    branch_cmp_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid1), .out_ready(1'b1), .out_taken(out_taken1), .out_tag(out_tag1)
`ifdef BRANCH_CMP_STATS_EN
        , .stat_total(stat_total1), .stat_taken(stat_taken1)
`endif
    );

    typedef struct {
        logic       taken;
        logic [7:0] tag;
        int         acc;
    } item_t;

    item_t       q2[$];
    int          t;
    int          last_pop;
    logic        p1_v;
    logic        p1_taken;
    logic [7:0]  p1_tag;
    logic        prev_stall;
    logic        prev_taken;
    logic [7:0]  prev_tag;
    int          n_pop;
    int          n_tk;
    int          checks;
    int          errors;

    function automatic logic ref_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) < $signed(b);
            3'd3:    return $signed(a) >= $signed(b);
            3'd4:    return a < b;
            3'd5:    return a >= b;
            3'd6:    return $signed(a) <= 32'sd0;
            default: return $signed(a) > 32'sd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    task automatic model_clear();
        q2.delete();
        last_pop   = -100;
        p1_v       = 1'b0;
        prev_stall = 1'b0;
        n_pop      = 0;
        n_tk       = 0;
    endtask

    // Drive one cycle at the negedge, compare everything, then advance the model.
    task automatic step(input logic iv, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [7:0] tag, input logic ordy,
                        output logic pushed, output logic popped);
        logic exp_v;
        logic exp_rdy;
        int   arr;
        item_t it;
        in_valid  = iv;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = ordy;
        #1;
        exp_v = 1'b0;
        if (q2.size() > 0) begin
            arr   = (q2[0].acc + 2 > last_pop + 1) ? q2[0].acc + 2 : last_pop + 1;
            exp_v = (t >= arr);
        end
        exp_rdy = !(q2.size() == 2 && !ordy);
        chk("s2_out_valid", 32'(out_valid2), 32'(exp_v));
        chk("s2_in_ready", 32'(in_ready2), 32'(exp_rdy));
        if (exp_v) begin
            chk("s2_out_tag", 32'(out_tag2), 32'(q2[0].tag));
            chk("s2_out_taken", 32'(out_taken2), 32'(q2[0].taken));
        end
        if (prev_stall) begin
            chk("s2_stall_tag", 32'(out_tag2), 32'(prev_tag));
            chk("s2_stall_taken", 32'(out_taken2), 32'(prev_taken));
        end
        chk("s1_in_ready", 32'(in_ready1), 32'd1);
        chk("s1_out_valid", 32'(out_valid1), 32'(p1_v));
        if (p1_v) begin
            chk("s1_out_tag", 32'(out_tag1), 32'(p1_tag));
            chk("s1_out_taken", 32'(out_taken1), 32'(p1_taken));
        end
`ifdef BRANCH_CMP_STATS_EN
        chk("stat_total", stat_total2, 32'(n_pop));
        chk("stat_taken", stat_taken2, 32'(n_tk));
`endif
        prev_stall = exp_v && !ordy;
        prev_tag   = out_tag2;
        prev_taken = out_taken2;
        popped = exp_v && ordy;
        pushed = iv && exp_rdy;
        if (popped) begin
            n_pop    = n_pop + 1;
            n_tk     = n_tk + int'(q2[0].taken);
            last_pop = t;
            void'(q2.pop_front());
        end
        p1_v = pushed;
        if (pushed) begin
            it.taken = ref_cond(op, a, b);
            it.tag   = tag;
            it.acc   = t;
            q2.push_back(it);
            p1_taken = it.taken;
            p1_tag   = tag;
        end
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic ps, pp;
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 8'd0, ordy, ps, pp);
    endtask

    task automatic rand_operands(output logic [31:0] a, output logic [31:0] b);
        logic [31:0] edges [5];
        edges[0] = 32'h0000_0000; edges[1] = 32'h0000_0001; edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000; edges[4] = 32'hFFFF_FFFF;
        case ($urandom_range(0, 3))
            0: begin a = $urandom; b = a; end
            1: begin a = $urandom; b = $urandom; end
            2: begin a = edges[$urandom_range(0, 4)]; b = edges[$urandom_range(0, 4)]; end
            default: begin b = $urandom; a = b + 32'($urandom_range(0, 2)) - 32'd1; end
        endcase
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid2", 32'(out_valid2), 32'd0);
        chk("rst_out_valid1", 32'(out_valid1), 32'd0);
        chk("rst_in_ready2", 32'(in_ready2), 32'd1);
        chk("rst_out_tag2", 32'(out_tag2), 32'd0);
`ifdef BRANCH_CMP_STATS_EN
        chk("rst_stat_total", stat_total2, 32'd0);
        chk("rst_stat_taken", stat_taken2, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    logic [2:0]  d_op  [8];
    logic [31:0] d_a   [8];
    logic [31:0] d_b   [8];
    logic        d_exp [8];

    initial begin
        logic ps, pp;
        int   acc_cnt;
        logic [31:0] ra, rb;
        checks = 0; errors = 0; t = 0;
        model_clear();
        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = 32'd0; in_b = 32'd0;
        in_tag = 8'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid2", 32'(out_valid2), 32'd0);
        chk("reset_in_ready2", 32'(in_ready2), 32'd1);
        chk("reset_out_tag2", 32'(out_tag2), 32'd0);
        chk("reset_out_taken2", 32'(out_taken2), 32'd0);
        chk("reset_out_valid1", 32'(out_valid1), 32'd0);
        chk("reset_out_tag1", 32'(out_tag1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Hand-computed directed table pins the model before it is trusted.
        d_op[0] = 3'd0; d_a[0] = 32'd5;          d_b[0] = 32'd5;          d_exp[0] = 1'b1;
        d_op[1] = 3'd1; d_a[1] = 32'd5;          d_b[1] = 32'd5;          d_exp[1] = 1'b0;
        d_op[2] = 3'd2; d_a[2] = 32'hFFFF_FFFF; d_b[2] = 32'd1;          d_exp[2] = 1'b1;
        d_op[3] = 3'd4; d_a[3] = 32'hFFFF_FFFF; d_b[3] = 32'd1;          d_exp[3] = 1'b0;
        d_op[4] = 3'd3; d_a[4] = 32'h8000_0000; d_b[4] = 32'h7FFF_FFFF; d_exp[4] = 1'b0;
        d_op[5] = 3'd5; d_a[5] = 32'h8000_0000; d_b[5] = 32'h7FFF_FFFF; d_exp[5] = 1'b1;
        d_op[6] = 3'd6; d_a[6] = 32'd0;          d_b[6] = 32'd9;          d_exp[6] = 1'b1;
        d_op[7] = 3'd7; d_a[7] = 32'd0;          d_b[7] = 32'd9;          d_exp[7] = 1'b0;
        for (int i = 0; i < 8; i++)
            chk("model_pin", 32'(ref_cond(d_op[i], d_a[i], d_b[i])), 32'(d_exp[i]));

        for (int i = 0; i < 8; i++)
            step(1'b1, d_op[i], d_a[i], d_b[i], 8'(i), 1'b1, ps, pp);
        idle(3, 1'b1);

        // Backpressure from empty: only two requests fit while the consumer stalls.
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            rand_operands(ra, rb);
            step(1'b1, 3'($urandom_range(0, 7)), ra, rb, 8'(16 + i), 1'b0, ps, pp);
            acc_cnt += int'(ps);
        end
        chk("stall_accepts", 32'(acc_cnt), 32'd2);
        idle(4, 1'b1);

        // Full pipe with push and pop together.
        step(1'b1, 3'd0, 32'd1, 32'd1, 8'd40, 1'b0, ps, pp);
        step(1'b1, 3'd1, 32'd1, 32'd1, 8'd41, 1'b0, ps, pp);
        step(1'b1, 3'd7, 32'd3, 32'd0, 8'd42, 1'b1, ps, pp);
        chk("pushpop_push", 32'(ps), 32'd1);
        chk("pushpop_pop", 32'(pp), 32'd1);
        idle(4, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            rand_operands(ra, rb);
            step(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), ra, rb,
                 8'($urandom), 1'($urandom_range(0, 9) < 6), ps, pp);
        end

        // Reset while stalled with results in flight.
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'd0, 32'd2, 32'd2, 8'(60 + i), 1'b0, ps, pp);
        async_reset_check();

        // Ten handshakes, four taken, then counters checked and cleared.
        for (int i = 0; i < 10; i++)
            step(1'b1, 3'd0, 32'd7, (i < 4) ? 32'd7 : 32'd8, 8'(80 + i), 1'b1, ps, pp);
        idle(3, 1'b1);
`ifdef BRANCH_CMP_STATS_EN
        chk("stats_total_10", stat_total2, 32'd10);
        chk("stats_taken_4", stat_taken2, 32'd4);
`endif
        async_reset_check();
        idle(2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_cmp_pipe.md
Name: branch_cmp_pipe

Overview:
- Parametrised, pipelined branch-condition comparator. Successor to the single-output 32-bit equality compare.
- Evaluates one of eight MIPS branch conditions on two WIDTH-bit operands.
- Returns a registered taken flag and a carried tag through an elastic valid/ready pipeline of STAGES registers.
- Sits between the register-file read and the PC-select logic, so the branch decision can be moved off the critical path.

Parameters:
- WIDTH, 32: operand width in bits. Must be at least 2.
- STAGES, 1: pipeline depth. Legal values are 1 or 2; any other value is an elaboration error.
- TAG_W, 8: width of the side-band tag carried alongside each request (for example, the PC index).

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  pipeline can accept a request this cycle.
- in_op  in  3  condition select (encoding in Behaviour).
- in_a  in  WIDTH  operand a (rs).
- in_b  in  WIDTH  operand b (rt). Ignored for LEZ/GTZ.
- in_tag  in  TAG_W  side-band tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  condition true.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Op encoding:
  - 000 EQ: a==b
  - 001 NE: a!=b
  - 010 LTS: signed a<b
  - 011 GES: signed a>=b
  - 100 LTU: unsigned a<b
  - 101 GEU: unsigned a>=b
  - 110 LEZ: signed a<=0
  - 111 GTZ: signed a>0
- Arithmetic rules:
  - Signed compares use two's complement at WIDTH bits.
  - No overflow artefacts: use sign-aware compare, not a subtract-and-sign test.
- Condition evaluation is combinational at input. The result is captured in stage 0 on handshake (in_valid && in_ready).
- Each stage holds {valid, taken, tag}. The last stage drives out_*.
- Stage k advances when its successor is empty or advancing. The last stage is advancing when out_valid && out_ready.
- in_ready = !v0 || stage0 advancing. This is a combinational path from out_ready through all stages; no skid buffer.
- Latency:
  - Result appears out_valid exactly STAGES cycles after the input handshake when there is no backpressure.
  - Throughput is 1 per cycle.
- Backpressure:
  - While out_valid && !out_ready, out_taken and out_tag are held stable. No stage changes.
  - in_ready drops only when all stages are full and stalled.
- Simultaneous pop of the last stage and push at input in the same cycle: both take effect; no bubble is inserted.
- Requests are never dropped, duplicated, or reordered.
- Reset: asynchronous assert clears all valid bits, taken, and tags to 0. Out-of-reset values: out_valid=0, out_taken=0, out_tag=0, in_ready=1.
- Reset mid-stall discards in-flight results; the consumer must not expect them.
- in_op values are all legal; no illegal-op handling is needed.

Optional Feature:
- Macro: BRANCH_CMP_STATS_EN.
- When defined, adds output ports stat_total[31:0] and stat_taken[31:0].
  - stat_total increments on every output handshake.
  - stat_taken increments on every output handshake with out_taken=1.
  - Both wrap modulo 2^32, reset to 0 by rst_n, and are registered.
- When undefined, the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package branch_cmp_pkg holds:
  - localparam op codes CMP_EQ..CMP_GTZ (3-bit)
  - typedef cmp_op_t
  - function cmp_eval(op, a, b), parametrised via WIDTH argument or package parameter
- Natural sub-module: branch_cmp_stage. One elastic register slice carrying {taken, tag} with valid/ready, instantiated STAGES times in a generate loop.

Test Plan:
- Reset and idle:
  - Stimulus: STAGES=1, rst_n low then high, no traffic.
  - Required: out_valid=0, in_ready=1, out_tag=0.
- All ops, positive result: STAGES=1, streaming every cycle with out_ready=1.
  - EQ(5,5) -> taken=1
  - NE(5,5) -> 0
  - LTS(0xFFFFFFFF,1) -> 1
  - LTU(0xFFFFFFFF,1) -> 0
  - GES(0x80000000,0x7FFFFFFF) -> 0
  - GEU(0x80000000,0x7FFFFFFF) -> 1
  - LEZ(0) -> 1
  - GTZ(0) -> 0
  - Each result arrives 1 cycle after its handshake, tags 0..7 in order.
- Latency at STAGES=2: same stream with tags 0..7 -> each result arrives exactly 2 cycles after its handshake; tags in order; 1 result per cycle.
- Backpressure: STAGES=2, out_ready=0 for 5 cycles while in_valid=1.
  - in_ready drops after 2 accepts; out_tag and out_taken remain stable during the stall.
  - On release, all results drain in order; none lost or duplicated.
- Simultaneous push/pop: pipeline full, out_ready=1 and in_valid=1 in the same cycle -> both handshakes complete; occupancy unchanged.
- Reset mid-stall and stats counters:
  - Stimulus: rst_n pulsed low while out_valid=1 and stalled.
  - Required: out_valid=0 immediately (asynchronous clear).
  - With BRANCH_CMP_STATS_EN defined, after 10 handshakes with 4 taken: stat_total=10, stat_taken=4. Both return to 0 on reset.
